// File: rtl/mem_access_unit_if.sv
// Data-memory bus between the MEM-stage access unit (master) and the data memory (slave).
interface mem_access_unit_if #(
  parameter int ADDR_W = 32
);
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [3:0]        dm_be;
  logic [31:0]       dm_wdata;
  logic              dm_ack;
  logic [31:0]       dm_rdata;

  modport master (
    output dm_req, dm_we, dm_addr, dm_be, dm_wdata,
    input  dm_ack, dm_rdata
  );

  modport slave (
    input  dm_req, dm_we, dm_addr, dm_be, dm_wdata,
    output dm_ack, dm_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM pipeline stage: issues byte/half/word loads and stores on the data-memory bus,
// stalls EX while waiting for the acknowledge, aligns/extends load data, and flags
// misaligned accesses and memory timeouts. Non-memory ops pass straight through.
module mem_access_unit #(
  parameter int ADDR_W     = 32,
  parameter int TIMEOUT    = 16,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              in_valid,
  input  logic [3:0]        in_op,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [31:0]       in_store_data,
  input  logic [4:0]        in_src_reg,
  input  logic [4:0]        in_dest,
  input  logic              in_wb,
  input  logic [31:0]       in_instr,
  input  logic              wb_we,
  input  logic [4:0]        wb_reg,
  input  logic [31:0]       wb_data,
  mem_access_unit_if.master dm,
  output logic              stall,
  output logic              pr_valid,
  output logic              pr_wb,
  output logic [4:0]        pr_dest,
  output logic [31:0]       pr_result,
  output logic [31:0]       pr_instr,
  output logic              misalign_err,
  output logic              timeout_err
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  localparam int              CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  // Bit position of the low end of byte lane 'off'.
  function automatic logic [4:0] lane_lsb(input logic [1:0] off);
    if (BIG_ENDIAN) return 5'd24 - {off, 3'b000};
    else            return {off, 3'b000};
  endfunction

  // Bit position of the low end of the halfword occupying lanes off and off+1.
  function automatic logic [4:0] half_lsb(input logic [1:0] off);
    if (BIG_ENDIAN) return 5'd16 - {off, 3'b000};
    else            return {off, 3'b000};
  endfunction

  function automatic logic is_mem_op(input logic [3:0] op);
    return (op >= OP_LB) && (op <= OP_SW);
  endfunction

  function automatic logic is_store_op(input logic [3:0] op);
    return (op >= OP_SB) && (op <= OP_SW);
  endfunction

  function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] off);
    logic r;
    case (op)
      OP_LH, OP_LHU, OP_SH: r = off[0];
      OP_LW, OP_SW:         r = (off != 2'b00);
      default:              r = 1'b0;
    endcase
    return r;
  endfunction

  // Loads always fetch the whole word; sub-word stores enable only their lanes.
  function automatic logic [3:0] byte_enable(input logic [3:0] op, input logic [1:0] off);
    logic [4:0] p;
    logic [3:0] r;
    case (op)
      OP_SB: begin
        p = lane_lsb(off);
        r = 4'b0001 << p[4:3];
      end
      OP_SH: begin
        p = half_lsb(off);
        r = 4'b0011 << p[4:3];
      end
      default: begin
        p = 5'd0;
        r = 4'b1111;
      end
    endcase
    return r;
  endfunction

  // Replicated store data lets the memory pick any lane without a shifter.
  function automatic logic [31:0] store_replicate(input logic [3:0] op, input logic [31:0] d);
    logic [31:0] r;
    case (op)
      OP_SB:   r = {4{d[7:0]}};
      OP_SH:   r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] load_extract(input logic [3:0] op, input logic [1:0] off,
                                               input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[lane_lsb(off) +: 8];
    h = w[half_lsb(off) +: 16];
    case (op)
      OP_LB:   r = {{24{b[7]}}, b};
      OP_LBU:  r = {24'd0, b};
      OP_LH:   r = {{16{h[15]}}, h};
      OP_LHU:  r = {16'd0, h};
      default: r = w;
    endcase
    return r;
  endfunction

  logic [0:0]        state_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [3:0]        op_r;
  logic [ADDR_W-1:0] addr_r;
  logic [4:0]        dest_r;
  logic              wb_r;
  logic [31:0]       instr_r;

  logic              dm_req_r;
  logic              dm_we_r;
  logic [ADDR_W-1:0] dm_addr_r;
  logic [3:0]        dm_be_r;
  logic [31:0]       dm_wdata_r;

  logic              pr_valid_r;
  logic              pr_wb_r;
  logic [4:0]        pr_dest_r;
  logic [31:0]       pr_result_r;
  logic [31:0]       pr_instr_r;
  logic              misalign_err_r;
  logic              timeout_err_r;

  logic              idle_s;
  logic              in_mem_s;
  logic              in_mis_s;
  logic [31:0]       st_data_s;
  logic              accept_s;
  logic              misalign_s;
  logic              pass_s;
  logic              done_s;
  logic              abort_s;

  // Decode the incoming op and the events that drive every register below.
  always_comb begin
    idle_s   = (state_r == ST_IDLE);
    in_mem_s = is_mem_op(in_op);
    in_mis_s = is_misaligned(in_op, in_addr[1:0]);
    if (wb_we && (wb_reg == in_src_reg) && (wb_reg != 5'd0)) begin
      st_data_s = wb_data;
    end else begin
      st_data_s = in_store_data;
    end
    accept_s   = idle_s && in_valid && in_mem_s && !in_mis_s;
    misalign_s = idle_s && in_valid && in_mis_s;
    pass_s     = idle_s && in_valid && !in_mem_s;
    done_s     = !idle_s && dm.dm_ack;
    abort_s    = !idle_s && !dm.dm_ack && (cnt_r == CNT_LAST);
  end

  // FSM and WAIT-cycle counter; an ack on the last allowed cycle wins over the timeout.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_r <= ST_IDLE;
      cnt_r   <= CNT_ZERO;
    end else if (accept_s) begin
      state_r <= ST_WAIT;
      cnt_r   <= CNT_ZERO;
    end else if (done_s || abort_s) begin
      state_r <= ST_IDLE;
      cnt_r   <= CNT_ZERO;
    end else if (!idle_s) begin
      cnt_r <= cnt_r + CNT_ONE;
    end
  end

  // Capture the accepted memory op so completion does not depend on EX inputs.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      op_r    <= 4'd0;
      addr_r  <= {ADDR_W{1'b0}};
      dest_r  <= 5'd0;
      wb_r    <= 1'b0;
      instr_r <= 32'd0;
    end else if (accept_s) begin
      op_r    <= in_op;
      addr_r  <= in_addr;
      dest_r  <= in_dest;
      wb_r    <= in_wb;
      instr_r <= in_instr;
    end
  end

  // Memory bus registers: loaded on accept, held stable for the whole request.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      dm_req_r   <= 1'b0;
      dm_we_r    <= 1'b0;
      dm_addr_r  <= {ADDR_W{1'b0}};
      dm_be_r    <= 4'd0;
      dm_wdata_r <= 32'd0;
    end else if (accept_s) begin
      dm_req_r   <= 1'b1;
      dm_we_r    <= is_store_op(in_op);
      dm_addr_r  <= {in_addr[ADDR_W-1:2], 2'b00};
      dm_be_r    <= byte_enable(in_op, in_addr[1:0]);
      dm_wdata_r <= store_replicate(in_op, st_data_s);
    end else if (done_s || abort_s) begin
      dm_req_r <= 1'b0;
    end
  end

  // MEM/WB pipeline register and one-cycle error flags.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pr_valid_r     <= 1'b0;
      pr_wb_r        <= 1'b0;
      pr_dest_r      <= 5'd0;
      pr_result_r    <= 32'd0;
      pr_instr_r     <= 32'd0;
      misalign_err_r <= 1'b0;
      timeout_err_r  <= 1'b0;
    end else begin
      misalign_err_r <= misalign_s;
      timeout_err_r  <= abort_s;
      if (done_s) begin
        pr_valid_r  <= 1'b1;
        pr_wb_r     <= is_store_op(op_r) ? 1'b0 : wb_r;
        pr_dest_r   <= dest_r;
        pr_instr_r  <= instr_r;
        pr_result_r <= is_store_op(op_r) ? 32'(addr_r)
                                         : load_extract(op_r, addr_r[1:0], dm.dm_rdata);
      end else if (abort_s) begin
        pr_valid_r  <= 1'b1;
        pr_wb_r     <= 1'b0;
        pr_dest_r   <= dest_r;
        pr_instr_r  <= instr_r;
        pr_result_r <= 32'(addr_r);
      end else if (pass_s) begin
        pr_valid_r  <= 1'b1;
        pr_wb_r     <= in_wb;
        pr_dest_r   <= in_dest;
        pr_instr_r  <= in_instr;
        pr_result_r <= 32'(in_addr);
      end else if (misalign_s) begin
        pr_valid_r  <= 1'b1;
        pr_wb_r     <= 1'b0;
        pr_dest_r   <= in_dest;
        pr_instr_r  <= in_instr;
        pr_result_r <= 32'(in_addr);
      end else begin
        pr_valid_r <= 1'b0;
        pr_wb_r    <= 1'b0;
      end
    end
  end

  assign stall        = (state_r == ST_WAIT);
  assign dm.dm_req    = dm_req_r;
  assign dm.dm_we     = dm_we_r;
  assign dm.dm_addr   = dm_addr_r;
  assign dm.dm_be     = dm_be_r;
  assign dm.dm_wdata  = dm_wdata_r;
  assign pr_valid     = pr_valid_r;
  assign pr_wb        = pr_wb_r;
  assign pr_dest      = pr_dest_r;
  assign pr_result    = pr_result_r;
  assign pr_instr     = pr_instr_r;
  assign misalign_err = misalign_err_r;
  assign timeout_err  = timeout_err_r;

endmodule
